mem_fill_responder: RTL and testbench

- Responder side of the cache-miss interface used by the pipelined CPU's instruction and data caches.
- Accepts fill (read-block) requests from the I-cache and D-cache and single-word write-through requests from the D-cache.
- Arbitrates between them and drives a multi-cycle, pipelined main memory.
- Streams returned words back to the requesting cache with word index and a done strobe.

---
 rtl/mem_fill_responder_pkg.sv | 43 ++++
 rtl/mem_fill_responder_if.sv | 58 +++++
 rtl/mem_fill_responder.sv | 119 +++++++++++
 tb/tb_mem_fill_responder.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_fill_responder_pkg.sv
// Shared types and constants for the cache-miss memory responder.
// Also imported by the I-cache and D-cache controllers.
package mem_fill_responder_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam int BLOCK_WORDS = 8;
    localparam int OFFSET_BITS = 4;
    localparam int WORD_IDX_W = 3;
    localparam int BLK_W = ADDR_W - OFFSET_BITS;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        FILL_DC,
        FILL_IC
    } state_t;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_IC,
        SEL_DC
    } req_sel_t;

    typedef logic [WORD_IDX_W-1:0] word_idx_t;

    function automatic req_sel_t fill_sel(state_t s);
        case (s)
            FILL_DC: return SEL_DC;
            FILL_IC: return SEL_IC;
            default: return SEL_NONE;
        endcase
    endfunction

    // Word address inside a block; byte 0 of each 16-bit word.
    function automatic logic [ADDR_W-1:0] word_addr(
        logic [BLK_W-1:0] blk,
        word_idx_t idx
    );
        return {blk, idx, 1'b0};
    endfunction

endpackage

// File: rtl/mem_fill_responder_if.sv
// Cache-side request/fill signals and the main-memory port of the responder.
// slave: the responder; master: caches plus memory.
interface mem_fill_responder_if;
    import mem_fill_responder_pkg::*;

    logic              ic_miss_req;
    logic [ADDR_W-1:0] ic_miss_addr;
    logic              ic_fill_valid;
    logic [DATA_W-1:0] ic_fill_data;
    word_idx_t         ic_fill_idx;
    logic              ic_fill_done;

    logic              dc_miss_req;
    logic [ADDR_W-1:0] dc_miss_addr;
    logic              dc_fill_valid;
    logic [DATA_W-1:0] dc_fill_data;
    word_idx_t         dc_fill_idx;
    logic              dc_fill_done;

    logic              dc_wr_req;
    logic [ADDR_W-1:0] dc_wr_addr;
    logic [DATA_W-1:0] dc_wr_data;
    logic              dc_wr_ack;

    logic              mem_en;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_rvalid;

    logic              busy;

    modport slave (
        input  ic_miss_req, ic_miss_addr,
        output ic_fill_valid, ic_fill_data, ic_fill_idx, ic_fill_done,
        input  dc_miss_req, dc_miss_addr,
        output dc_fill_valid, dc_fill_data, dc_fill_idx, dc_fill_done,
        input  dc_wr_req, dc_wr_addr, dc_wr_data,
        output dc_wr_ack,
        output mem_en, mem_wr, mem_addr, mem_wdata,
        input  mem_rdata, mem_rvalid,
        output busy
    );

    modport master (
        output ic_miss_req, ic_miss_addr,
        input  ic_fill_valid, ic_fill_data, ic_fill_idx, ic_fill_done,
        output dc_miss_req, dc_miss_addr,
        input  dc_fill_valid, dc_fill_data, dc_fill_idx, dc_fill_done,
        output dc_wr_req, dc_wr_addr, dc_wr_data,
        input  dc_wr_ack,
        input  mem_en, mem_wr, mem_addr, mem_wdata,
        output mem_rdata, mem_rvalid,
        input  busy
    );

endinterface

// File: rtl/mem_fill_responder.sv
// Arbitrates I/D fills and D write-throughs onto a pipelined main memory
// and streams returned words back to the owning cache.
module mem_fill_responder
    import mem_fill_responder_pkg::*;
#(
    parameter int MEM_LATENCY = 4
) (
    input logic clk,
    input logic rst,
    mem_fill_responder_if.slave bus
);

    localparam int LAT_W = $clog2(MEM_LATENCY + 1);
    localparam word_idx_t LAST_IDX = word_idx_t'(BLOCK_WORDS - 1);

    state_t           state;
    logic [BLK_W-1:0] blk_q;
    word_idx_t        issue_cnt;
    word_idx_t        issue_nxt;
    word_idx_t        ret_cnt;
    logic [LAT_W-1:0] lat_cnt;
    logic             ret_ok;
    logic             take;
    logic             take_ic;
    logic             take_dc;
    req_sel_t         sel;

    // rvalid earlier than the first issue's latency cannot be ours
    assign ret_ok    = lat_cnt == LAT_W'(MEM_LATENCY);
    assign sel       = fill_sel(state);
    assign take      = (sel != SEL_NONE) && ret_ok && bus.mem_rvalid;
    assign take_ic   = take && (sel == SEL_IC);
    assign take_dc   = take && (sel == SEL_DC);
    assign issue_nxt = issue_cnt + 1'b1;

    assign bus.ic_fill_valid = take_ic;
    assign bus.ic_fill_data  = take_ic ? bus.mem_rdata : '0;
    assign bus.ic_fill_idx   = take_ic ? ret_cnt : '0;
    assign bus.ic_fill_done  = take_ic && (ret_cnt == LAST_IDX);

    assign bus.dc_fill_valid = take_dc;
    assign bus.dc_fill_data  = take_dc ? bus.mem_rdata : '0;
    assign bus.dc_fill_idx   = take_dc ? ret_cnt : '0;
    assign bus.dc_fill_done  = take_dc && (ret_cnt == LAST_IDX);

    assign bus.busy = state != IDLE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            blk_q         <= '0;
            issue_cnt     <= '0;
            ret_cnt       <= '0;
            lat_cnt       <= '0;
            bus.mem_en    <= 1'b0;
            bus.mem_wr    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.dc_wr_ack <= 1'b0;
        end else begin
            bus.dc_wr_ack <= 1'b0;
            unique case (state)
                IDLE: begin
                    issue_cnt <= '0;
                    ret_cnt   <= '0;
                    lat_cnt   <= '0;
                    priority case (1'b1)
                        bus.dc_wr_req: begin
                            state         <= WRITE;
                            bus.mem_en    <= 1'b1;
                            bus.mem_wr    <= 1'b1;
                            bus.mem_addr  <= bus.dc_wr_addr;
                            bus.mem_wdata <= bus.dc_wr_data;
                            bus.dc_wr_ack <= 1'b1;
                        end
                        bus.dc_miss_req: begin
                            state        <= FILL_DC;
                            blk_q        <= bus.dc_miss_addr[ADDR_W-1:OFFSET_BITS];
                            bus.mem_en   <= 1'b1;
                            bus.mem_wr   <= 1'b0;
                            bus.mem_addr <= word_addr(
                                bus.dc_miss_addr[ADDR_W-1:OFFSET_BITS], '0);
                        end
                        bus.ic_miss_req: begin
                            state        <= FILL_IC;
                            blk_q        <= bus.ic_miss_addr[ADDR_W-1:OFFSET_BITS];
                            bus.mem_en   <= 1'b1;
                            bus.mem_wr   <= 1'b0;
                            bus.mem_addr <= word_addr(
                                bus.ic_miss_addr[ADDR_W-1:OFFSET_BITS], '0);
                        end
                        default: ;
                    endcase
                end
                WRITE: begin
                    state      <= IDLE;
                    bus.mem_en <= 1'b0;
                    bus.mem_wr <= 1'b0;
                end
                default: begin
                    if (!ret_ok) lat_cnt <= lat_cnt + 1'b1;
                    if (bus.mem_en) begin
                        if (issue_cnt == LAST_IDX) begin
                            bus.mem_en <= 1'b0;
                        end else begin
                            issue_cnt    <= issue_nxt;
                            bus.mem_addr <= word_addr(blk_q, issue_nxt);
                        end
                    end
                    if (take) begin
                        if (ret_cnt == LAST_IDX) state <= IDLE;
                        else ret_cnt <= ret_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_fill_responder.sv
// Scoreboard bench: stimulus queues expected memory issues, fill words
// and acks; negedge monitors pop and compare what the DUTs present.
module tb_mem_fill_responder;

    typedef struct {
        int          cyc;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
    } mem_t;

    typedef struct {
        int          cyc;
        logic [2:0]  idx;
        logic [15:0] data;
        logic        done;
    } fill_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    mem_t  mem_q[$];
    fill_t icf_q[$];
    fill_t dcf_q[$];
    int    ack_q[$];
    mem_t  m1_q[$];
    fill_t f1_q[$];

    mem_fill_responder_if bus ();
    mem_fill_responder_if bus1 ();

    mem_fill_responder #(.MEM_LATENCY(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    mem_fill_responder #(.MEM_LATENCY(1)) dut1 (
        .clk(clk),
        .rst(rst),
        .bus(bus1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] mdata(logic [15:0] a);
        return a ^ 16'hC3A5;
    endfunction

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
        end
    endfunction

    // Memory models: latency 4 and latency 1, both cleared by rst.
    logic [3:0]  v0;
    logic [15:0] a0 [4];
    logic        v1;
    logic [15:0] a1;

    always @(posedge clk) begin
        if (rst) begin
            v0 <= '0;
            v1 <= 1'b0;
        end else begin
            v0    <= {v0[2:0], bus.mem_en && !bus.mem_wr};
            a0[0] <= bus.mem_addr;
            for (int i = 1; i < 4; i++) a0[i] <= a0[i-1];
            v1 <= bus1.mem_en && !bus1.mem_wr;
            a1 <= bus1.mem_addr;
        end
    end

    assign bus.mem_rvalid  = v0[3];
    assign bus.mem_rdata   = v0[3] ? mdata(a0[3]) : 16'h0;
    assign bus1.mem_rvalid = v1;
    assign bus1.mem_rdata  = v1 ? mdata(a1) : 16'h0;

    always @(negedge clk) begin
        mem_t  m;
        fill_t f;
        if (bus.mem_en) begin
            if (mem_q.size() == 0) chk("mem_unexp", bus.mem_en, 0);
            else begin
                m = mem_q.pop_front();
                chk("mem_cyc", cyc, m.cyc);
                chk("mem_wr", bus.mem_wr, m.wr);
                chk("mem_addr", bus.mem_addr, m.addr);
                if (m.wr) chk("mem_wdata", bus.mem_wdata, m.wdata);
            end
        end
        if (bus.ic_fill_valid) begin
            if (icf_q.size() == 0) chk("ic_unexp", bus.ic_fill_valid, 0);
            else begin
                f = icf_q.pop_front();
                chk("ic_cyc", cyc, f.cyc);
                chk("ic_idx", bus.ic_fill_idx, f.idx);
                chk("ic_data", bus.ic_fill_data, f.data);
                chk("ic_done", bus.ic_fill_done, f.done);
            end
        end else begin
            chk("ic_quiet", {bus.ic_fill_data, bus.ic_fill_idx, bus.ic_fill_done}, 0);
        end
        if (bus.dc_fill_valid) begin
            if (dcf_q.size() == 0) chk("dc_unexp", bus.dc_fill_valid, 0);
            else begin
                f = dcf_q.pop_front();
                chk("dc_cyc", cyc, f.cyc);
                chk("dc_idx", bus.dc_fill_idx, f.idx);
                chk("dc_data", bus.dc_fill_data, f.data);
                chk("dc_done", bus.dc_fill_done, f.done);
            end
        end else begin
            chk("dc_quiet", {bus.dc_fill_data, bus.dc_fill_idx, bus.dc_fill_done}, 0);
        end
        if (bus.dc_wr_ack) begin
            if (ack_q.size() == 0) chk("ack_unexp", bus.dc_wr_ack, 0);
            else chk("ack_cyc", cyc, ack_q.pop_front());
        end
    end

    always @(negedge clk) begin
        mem_t  m;
        fill_t f;
        if (bus1.mem_en) begin
            if (m1_q.size() == 0) chk("l1_mem_unexp", bus1.mem_en, 0);
            else begin
                m = m1_q.pop_front();
                chk("l1_mem_cyc", cyc, m.cyc);
                chk("l1_mem_wr", bus1.mem_wr, m.wr);
                chk("l1_mem_addr", bus1.mem_addr, m.addr);
            end
        end
        if (bus1.ic_fill_valid) begin
            if (f1_q.size() == 0) chk("l1_ic_unexp", bus1.ic_fill_valid, 0);
            else begin
                f = f1_q.pop_front();
                chk("l1_ic_cyc", cyc, f.cyc);
                chk("l1_ic_idx", bus1.ic_fill_idx, f.idx);
                chk("l1_ic_data", bus1.ic_fill_data, f.data);
                chk("l1_ic_done", bus1.ic_fill_done, f.done);
            end
        end
        if (bus1.dc_fill_valid || bus1.dc_wr_ack) begin
            chk("l1_dc_unexp", {bus1.dc_fill_valid, bus1.dc_wr_ack,
                bus1.dc_fill_done, bus1.dc_fill_idx, bus1.dc_fill_data}, 0);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic exp_fill(input bit ic, input int acc, input logic [15:0] a,
                            input int lat, input bit l1, input int ni, input int nr);
        for (int i = 0; i < 8; i++) begin
            mem_t  m;
            fill_t f;
            m.cyc   = acc + 1 + i;
            m.wr    = 1'b0;
            m.addr  = {a[15:4], 3'(i), 1'b0};
            m.wdata = '0;
            f.cyc   = acc + 1 + i + lat;
            f.idx   = 3'(i);
            f.data  = mdata(m.addr);
            f.done  = (i == 7);
            if (l1) begin
                if (i < ni) m1_q.push_back(m);
                if (i < nr) f1_q.push_back(f);
            end else begin
                if (i < ni) mem_q.push_back(m);
                if (i < nr) begin
                    if (ic) icf_q.push_back(f);
                    else dcf_q.push_back(f);
                end
            end
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_mem"}, {bus.mem_en, bus.mem_wr, bus.dc_wr_ack}, 0);
        chk({tag, "_maddr"}, bus.mem_addr, 0);
        chk({tag, "_mwdata"}, bus.mem_wdata, 0);
        chk({tag, "_fill"}, {bus.ic_fill_valid, bus.dc_fill_valid,
            bus.ic_fill_done, bus.dc_fill_done}, 0);
        chk({tag, "_l1busy"}, bus1.busy, 0);
    endtask

    initial begin
        int c;
        bus.ic_miss_req  = 0; bus.ic_miss_addr = '0;
        bus.dc_miss_req  = 0; bus.dc_miss_addr = '0;
        bus.dc_wr_req    = 0; bus.dc_wr_addr   = '0;
        bus.dc_wr_data   = '0;
        bus1.ic_miss_req = 0; bus1.ic_miss_addr = '0;
        bus1.dc_miss_req = 0; bus1.dc_miss_addr = '0;
        bus1.dc_wr_req   = 0; bus1.dc_wr_addr   = '0;
        bus1.dc_wr_data  = '0;

        tick(3);
        chk_quiet("reset");
        rst = 0;
        tick(2);

        // I fill, offset bits ignored
        c = cyc;
        bus.ic_miss_req = 1; bus.ic_miss_addr = 16'h1236;
        exp_fill(1, c, 16'h1230, 4, 0, 8, 8);
        tick(13);
        bus.ic_miss_req = 0;
        tick(2);

        // write-through
        c = cyc;
        bus.dc_wr_req = 1; bus.dc_wr_addr = 16'h0040; bus.dc_wr_data = 16'hBEEF;
        mem_q.push_back('{cyc: c + 1, wr: 1'b1, addr: 16'h0040, wdata: 16'hBEEF});
        ack_q.push_back(c + 1);
        tick(1);
        chk("wr_busy_hi", bus.busy, 1);
        tick(1);
        bus.dc_wr_req = 0;
        chk("wr_busy_lo", bus.busy, 0);
        tick(2);

        // D and I miss together: D first, I 2 cycles after dc done
        c = cyc;
        bus.dc_miss_req = 1; bus.dc_miss_addr = 16'h2000;
        bus.ic_miss_req = 1; bus.ic_miss_addr = 16'h0100;
        exp_fill(0, c, 16'h2000, 4, 0, 8, 8);
        exp_fill(1, c + 13, 16'h0100, 4, 0, 8, 8);
        tick(13);
        bus.dc_miss_req = 0;
        tick(13);
        bus.ic_miss_req = 0;
        tick(2);

        // write arrives during 3rd issue of an I fill
        c = cyc;
        bus.ic_miss_req = 1; bus.ic_miss_addr = 16'h0450;
        exp_fill(1, c, 16'h0450, 4, 0, 8, 8);
        mem_q.push_back('{cyc: c + 14, wr: 1'b1, addr: 16'h0A0C, wdata: 16'h1234});
        ack_q.push_back(c + 14);
        tick(3);
        bus.dc_wr_req = 1; bus.dc_wr_addr = 16'h0A0C; bus.dc_wr_data = 16'h1234;
        tick(10);
        bus.ic_miss_req = 0;
        tick(2);
        bus.dc_wr_req = 0;
        tick(2);

        // reset during 5th issue of a D fill
        c = cyc;
        bus.dc_miss_req = 1; bus.dc_miss_addr = 16'h3000;
        exp_fill(0, c, 16'h3000, 4, 0, 5, 1);
        tick(5);
        rst = 1;
        bus.dc_miss_req = 0;
        tick(1);
        chk_quiet("abort");
        rst = 0;
        tick(1);
        c = cyc;
        bus.ic_miss_req = 1; bus.ic_miss_addr = 16'h0300;
        exp_fill(1, c, 16'h0300, 4, 0, 8, 8);
        tick(13);
        bus.ic_miss_req = 0;
        tick(2);

        // latency-1 instance: done 9 cycles after accept
        c = cyc;
        bus1.ic_miss_req = 1; bus1.ic_miss_addr = 16'h0010;
        exp_fill(1, c, 16'h0010, 1, 1, 8, 8);
        tick(10);
        bus1.ic_miss_req = 0;
        tick(3);

        chk("queues_empty", mem_q.size() + icf_q.size() + dcf_q.size()
            + ack_q.size() + m1_q.size() + f1_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
